// File: rtl/sc_level_controller_if.sv
// Control/status bundle between the level controller and the Frogger playfield datapath.
// No valid/ready here: inputs are level-sampled every clock, outputs are Moore values that change only on clock edges.
interface sc_level_controller_if;
    logic        SC_LEVELCONTROLLER_start_InLow;
    logic        SC_LEVELCONTROLLER_arrived_InHigh;
    logic        SC_LEVELCONTROLLER_collision_InHigh;
    logic        SC_LEVELCONTROLLER_clear_OutLow;
    logic        SC_LEVELCONTROLLER_play_OutHigh;
    logic [2:0]  SC_LEVELCONTROLLER_level;
    logic [1:0]  SC_LEVELCONTROLLER_lives;
    logic [25:0] SC_LEVELCONTROLLER_speed;
    logic        SC_LEVELCONTROLLER_gameover_OutHigh;
    logic        SC_LEVELCONTROLLER_victory_OutHigh;
    logic [2:0]  SC_LEVELCONTROLLER_state;

    // controller side
    modport master (
        input  SC_LEVELCONTROLLER_start_InLow, SC_LEVELCONTROLLER_arrived_InHigh,
               SC_LEVELCONTROLLER_collision_InHigh,
        output SC_LEVELCONTROLLER_clear_OutLow, SC_LEVELCONTROLLER_play_OutHigh,
               SC_LEVELCONTROLLER_level, SC_LEVELCONTROLLER_lives, SC_LEVELCONTROLLER_speed,
               SC_LEVELCONTROLLER_gameover_OutHigh, SC_LEVELCONTROLLER_victory_OutHigh,
               SC_LEVELCONTROLLER_state
    );

    // pushbutton / playfield side
    modport slave (
        output SC_LEVELCONTROLLER_start_InLow, SC_LEVELCONTROLLER_arrived_InHigh,
               SC_LEVELCONTROLLER_collision_InHigh,
        input  SC_LEVELCONTROLLER_clear_OutLow, SC_LEVELCONTROLLER_play_OutHigh,
               SC_LEVELCONTROLLER_level, SC_LEVELCONTROLLER_lives, SC_LEVELCONTROLLER_speed,
               SC_LEVELCONTROLLER_gameover_OutHigh, SC_LEVELCONTROLLER_victory_OutHigh,
               SC_LEVELCONTROLLER_state
    );
endinterface

// File: rtl/sc_level_controller.sv
// Frogger game-flow FSM: start/load/play/hold/end phases, level and lives counters, lane speed.
// Optional macro SC_LEVELCONTROLLER_BONUS_LIFE_EN grants +1 life (saturating at 3) on each level-up.
module sc_level_controller #(
    parameter int          MAX_LEVEL   = 4,
    parameter int          LIVES_INIT  = 3,
    parameter int          HOLD_CYCLES = 50000000,
    parameter logic [25:0] SPEED_BASE  = 26'd25000000,
    parameter logic [25:0] SPEED_STEP  = 26'd5000000
) (
    input logic                   SC_LEVELCONTROLLER_CLOCK_50,
    input logic                   SC_LEVELCONTROLLER_RESET_InLow,
    sc_level_controller_if.master bus
);
    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_IDLE       = 3'd1,
        ST_LOAD       = 3'd2,
        ST_PLAY       = 3'd3,
        ST_WIN_HOLD   = 3'd4,
        ST_DEATH_HOLD = 3'd5,
        ST_GAME_OVER  = 3'd6,
        ST_VICTORY    = 3'd7
    } state_t;

    localparam int               TIMER_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]       LEVEL_MAX   = 3'(MAX_LEVEL);
    localparam logic [1:0]       LIVES_START = 2'(LIVES_INIT);

    state_t               state_q, state_d;
    logic [2:0]           level_q, level_d;
    logic [1:0]           lives_q, lives_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 start_prev_q;
    logic                 start_edge;

    // One event per press: previous sample high, current sample low.
    assign start_edge = start_prev_q & ~bus.SC_LEVELCONTROLLER_start_InLow;

    always_ff @(posedge SC_LEVELCONTROLLER_CLOCK_50) begin
        if (!SC_LEVELCONTROLLER_RESET_InLow) begin
            state_q      <= ST_RESET;
            level_q      <= 3'd1;
            lives_q      <= LIVES_START;
            timer_q      <= '0;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            timer_q      <= timer_d;
            start_prev_q <= bus.SC_LEVELCONTROLLER_start_InLow;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        timer_d = '0;
        case (state_q)
            ST_RESET: state_d = ST_IDLE;
            ST_IDLE:  if (start_edge) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_PLAY;
            ST_PLAY: begin
                // Collision wins over a simultaneous arrival.
                if (bus.SC_LEVELCONTROLLER_collision_InHigh) begin
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = ST_GAME_OVER;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        state_d = ST_DEATH_HOLD;
                    end
                end else if (bus.SC_LEVELCONTROLLER_arrived_InHigh) begin
                    if (level_q >= LEVEL_MAX) begin
                        state_d = ST_VICTORY;
                    end else begin
                        level_d = level_q + 3'd1;
                        state_d = ST_WIN_HOLD;
`ifdef SC_LEVELCONTROLLER_BONUS_LIFE_EN
                        if (lives_q != 2'd3) lives_d = lives_q + 2'd1;
`endif
                    end
                end
            end
            ST_WIN_HOLD, ST_DEATH_HOLD: begin
                if (timer_q == TIMER_LAST) state_d = ST_LOAD;
                else                       timer_d = timer_q + 1'b1;
            end
            ST_GAME_OVER, ST_VICTORY: begin
                if (start_edge) begin
                    level_d = 3'd1;
                    lives_d = LIVES_START;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign bus.SC_LEVELCONTROLLER_clear_OutLow     = !(state_q == ST_RESET || state_q == ST_LOAD);
    assign bus.SC_LEVELCONTROLLER_play_OutHigh     = (state_q == ST_PLAY);
    assign bus.SC_LEVELCONTROLLER_gameover_OutHigh = (state_q == ST_GAME_OVER);
    assign bus.SC_LEVELCONTROLLER_victory_OutHigh  = (state_q == ST_VICTORY);
    assign bus.SC_LEVELCONTROLLER_level            = level_q;
    assign bus.SC_LEVELCONTROLLER_lives            = lives_q;
    assign bus.SC_LEVELCONTROLLER_state            = state_q;
    assign bus.SC_LEVELCONTROLLER_speed = SPEED_BASE - ((26'(level_q) - 26'd1) * SPEED_STEP);
endmodule
